// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, extension codes, instruction field positions,
// the NOP word and the instruction-fetch state encoding.
package cpu_isa_pkg;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ANDI  = 4'h1;
   localparam logic [3:0] OP_ORI   = 4'h2;
   localparam logic [3:0] OP_XORI  = 4'h3;
   localparam logic [3:0] OP_MEM   = 4'h4;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_SUBI  = 4'h9;
   localparam logic [3:0] OP_CMPI  = 4'hb;
   localparam logic [3:0] OP_BCOND = 4'hc;
   localparam logic [3:0] OP_MOVI  = 4'hd;
   localparam logic [3:0] OP_LUI   = 4'hf;

   // Extension codes carried in opCode2 when opCode1 == OP_MEM
   localparam logic [3:0] EXT_LB    = 4'h0;
   localparam logic [3:0] EXT_SB    = 4'h4;
   localparam logic [3:0] EXT_JAL   = 4'h8;
   localparam logic [3:0] EXT_JCOND = 4'hc;

   localparam int OP1_HI   = 15;
   localparam int OP1_LO   = 12;
   localparam int COND_HI  = 11;
   localparam int COND_LO  = 8;
   localparam int OP2_HI   = 7;
   localparam int OP2_LO   = 4;
   localparam int SHIFT_HI = 3;
   localparam int SHIFT_LO = 0;
   localparam int IMM8_HI  = 7;

   localparam logic [15:0] ISA_NOP_WORD = 16'h0000;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_WAIT    = 2'd1,
      FETCH_CAPTURE = 2'd2
   } fetch_state_e;

   function automatic logic is_illegal(input logic [15:0] word);
      logic [3:0] op1;
      logic [3:0] op2;
      logic       ill;
      op1 = word[OP1_HI:OP1_LO];
      op2 = word[OP2_HI:OP2_LO];
      case (op1)
         OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SHIFT,
         OP_SUBI, OP_CMPI, OP_BCOND, OP_MOVI, OP_LUI: ill = 1'b0;
         OP_MEM: ill = !((op2 == EXT_LB) || (op2 == EXT_SB) ||
                         (op2 == EXT_JAL) || (op2 == EXT_JCOND));
         default: ill = 1'b1;
      endcase
      return ill;
   endfunction

endpackage

// File: rtl/ir_field_split.sv
// Combinational instruction field splitter; also reused by the control FSM
// for its immediate path.
module ir_field_split
   import cpu_isa_pkg::*;
(
   input  logic [15:0] ir,
   input  logic        zero_ext,
   output logic [3:0]  op_code1,
   output logic [3:0]  cond_code,
   output logic [3:0]  op_code2,
   output logic [3:0]  shift_amt,
   output logic [15:0] imm16
);

   assign op_code1  = ir[OP1_HI:OP1_LO];
   assign cond_code = ir[COND_HI:COND_LO];
   assign op_code2  = ir[OP2_HI:OP2_LO];
   assign shift_amt = ir[SHIFT_HI:SHIFT_LO];

   assign imm16[IMM8_HI:0] = ir[IMM8_HI:0];

   genvar gi;
   generate
      for (gi = IMM8_HI + 1; gi < 16; gi++) begin : g_ext
         assign imm16[gi] = ~zero_ext & ir[IMM8_HI];
      end
   endgenerate

endmodule

// File: rtl/instr_reg_fetch.sv
// Instruction register: waits out the memory read latency after fetch_start,
// captures the returned word and splits it into fields. Optional ILLEGAL_OP_DETECT_EN.
module instr_reg_fetch
   import cpu_isa_pkg::*;
#(
   parameter int                DATA_W       = 16,
   parameter int                READ_LATENCY = 2,
   parameter logic [DATA_W-1:0] NOP_WORD     = ISA_NOP_WORD
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_start,
   input  logic              flush,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              zero_ext,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   output logic              fetch_busy,
   output logic [3:0]        opCode1,
   output logic [3:0]        condCode,
   output logic [3:0]        opCode2,
   output logic [3:0]        shiftAmt,
   output logic [15:0]       imm16,
   output logic              illegal_op
);

   localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

   fetch_state_e      state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        cnt_inc;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              fetch_busy_q, fetch_busy_d;

   // The CAPTURE cycle is the one in which mem_rdata carries the requested word,
   // so the state advances when the next count value reaches LAST_CNT.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ir_d         = ir_q;
      ir_valid_d   = ir_valid_q;
      fetch_busy_d = fetch_busy_q;
      cnt_inc      = (cnt_q == LAST_CNT) ? cnt_q : cnt_q + 3'd1;

      case (state_q)
         FETCH_IDLE: begin
            cnt_d = '0;
         end
         FETCH_WAIT: begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == LAST_CNT) ? FETCH_CAPTURE : FETCH_WAIT;
         end
         FETCH_CAPTURE: begin
            ir_d         = mem_rdata;
            ir_valid_d   = 1'b1;
            fetch_busy_d = 1'b0;
            cnt_d        = '0;
            state_d      = FETCH_IDLE;
         end
         default: begin
            state_d = FETCH_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A new request restarts the count; any capture above still lands in ir
      if (fetch_start) begin
         ir_valid_d   = 1'b0;
         fetch_busy_d = 1'b1;
         cnt_d        = '0;
         state_d      = (LAST_CNT == 3'd0) ? FETCH_CAPTURE : FETCH_WAIT;
      end

      if (flush) begin
         ir_d         = NOP_WORD;
         ir_valid_d   = 1'b0;
         fetch_busy_d = 1'b0;
         cnt_d        = '0;
         state_d      = FETCH_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH_IDLE;
         cnt_q        <= '0;
         ir_q         <= NOP_WORD;
         ir_valid_q   <= 1'b0;
         fetch_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ir_q         <= ir_d;
         ir_valid_q   <= ir_valid_d;
         fetch_busy_q <= fetch_busy_d;
      end
   end

   assign ir         = ir_q;
   assign ir_valid   = ir_valid_q;
   assign fetch_busy = fetch_busy_q;

   ir_field_split u_split (
      .ir        (ir_q[15:0]),
      .zero_ext  (zero_ext),
      .op_code1  (opCode1),
      .cond_code (condCode),
      .op_code2  (opCode2),
      .shift_amt (shiftAmt),
      .imm16     (imm16)
   );

`ifdef ILLEGAL_OP_DETECT_EN
   logic illegal_q, illegal_d;

   always_comb begin
      illegal_d = illegal_q;
      if (state_q == FETCH_CAPTURE) begin
         illegal_d = is_illegal(mem_rdata[15:0]);
      end
      if (fetch_start || flush) begin
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

endmodule
